// File: rtl/axi_reg_slice_if.sv
// AXI4 bundle (no user signals) shared by both sides of axi_reg_slice.
// The master modport drives AW/W/AR and the B/R ready signals; slave is its mirror.
interface axi_reg_slice_if #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 16
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [ID_WIDTH-1:0]     rid;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rid, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rid, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_reg_slice.sv
// Full-throughput AXI4 register slice: one two-entry skid buffer per channel so that
// every valid, ready and payload signal leaving the block comes straight from a flop.
module axi_reg_slice #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    axi_reg_slice_if.slave   s_axi,
    axi_reg_slice_if.master  m_axi
);
    localparam int NCH  = 5;   // 0:AW 1:W 2:AR 3:B 4:R
    localparam int AX_W = ADDR_WIDTH + ID_WIDTH + 25;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int R_W  = DATA_WIDTH + ID_WIDTH + 3;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [NCH-1:0] in_valid, in_ready, out_valid, out_ready;
    logic [NCH-1:0] main_load, main_from_skid, skid_load;

    assign in_valid  = {m_axi.rvalid, m_axi.bvalid, s_axi.arvalid, s_axi.wvalid, s_axi.awvalid};
    assign out_ready = {s_axi.rready, s_axi.bready, m_axi.arready, m_axi.wready, m_axi.awready};

    assign s_axi.awready = in_ready[0];
    assign s_axi.wready  = in_ready[1];
    assign s_axi.arready = in_ready[2];
    assign m_axi.bready  = in_ready[3];
    assign m_axi.rready  = in_ready[4];

    assign m_axi.awvalid = out_valid[0];
    assign m_axi.wvalid  = out_valid[1];
    assign m_axi.arvalid = out_valid[2];
    assign s_axi.bvalid  = out_valid[3];
    assign s_axi.rvalid  = out_valid[4];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [1:0] state_q, state_d;
            logic       in_ready_q, out_valid_q;
            logic       in_fire, out_fire;
            logic       load_main, load_skid, sel_skid;

            always_comb begin
                in_fire   = in_valid[gi] & in_ready_q;
                out_fire  = out_valid_q & out_ready[gi];
                state_d   = state_q;
                load_main = 1'b0;
                load_skid = 1'b0;
                sel_skid  = 1'b0;
                case (state_q)
                    EMPTY: if (in_fire) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                    ONE: begin
                        if (in_fire && !out_fire) begin
                            state_d   = FULL;
                            load_skid = 1'b1;
                        end else if (!in_fire && out_fire) begin
                            state_d = EMPTY;
                        end else if (in_fire && out_fire) begin
                            load_main = 1'b1;
                        end
                    end
                    FULL: if (out_fire) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                        sel_skid  = 1'b1;
                    end
                    default: state_d = EMPTY;
                endcase
            end

            // Handshake flags are registered copies of the next state, never decoded from it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    in_ready_q  <= (state_d != FULL);
                    out_valid_q <= (state_d != EMPTY);
                end
            end

            assign in_ready[gi]       = in_ready_q;
            assign out_valid[gi]      = out_valid_q;
            assign main_load[gi]      = load_main & ~reset;
            assign skid_load[gi]      = load_skid & ~reset;
            assign main_from_skid[gi] = sel_skid;
        end
    endgenerate

    logic [AX_W-1:0] aw_in, aw_main_q, aw_skid_q, ar_in, ar_main_q, ar_skid_q;
    logic [W_W-1:0]  w_in, w_main_q, w_skid_q;
    logic [B_W-1:0]  b_in, b_main_q, b_skid_q;
    logic [R_W-1:0]  r_in, r_main_q, r_skid_q;

    assign aw_in = {s_axi.awaddr, s_axi.awid, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                    s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos};
    assign ar_in = {s_axi.araddr, s_axi.arid, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                    s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};
    assign w_in  = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
    assign b_in  = {m_axi.bid, m_axi.bresp};
    assign r_in  = {m_axi.rdata, m_axi.rid, m_axi.rresp, m_axi.rlast};

    // Payload registers carry no reset; they are only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (skid_load[0]) aw_skid_q <= aw_in;
        if (main_load[0]) aw_main_q <= main_from_skid[0] ? aw_skid_q : aw_in;
        if (skid_load[1]) w_skid_q  <= w_in;
        if (main_load[1]) w_main_q  <= main_from_skid[1] ? w_skid_q : w_in;
        if (skid_load[2]) ar_skid_q <= ar_in;
        if (main_load[2]) ar_main_q <= main_from_skid[2] ? ar_skid_q : ar_in;
        if (skid_load[3]) b_skid_q  <= b_in;
        if (main_load[3]) b_main_q  <= main_from_skid[3] ? b_skid_q : b_in;
        if (skid_load[4]) r_skid_q  <= r_in;
        if (main_load[4]) r_main_q  <= main_from_skid[4] ? r_skid_q : r_in;
    end

    assign {m_axi.awaddr, m_axi.awid, m_axi.awlen, m_axi.awsize, m_axi.awburst,
            m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos} = aw_main_q;
    assign {m_axi.araddr, m_axi.arid, m_axi.arlen, m_axi.arsize, m_axi.arburst,
            m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos} = ar_main_q;
    assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast}            = w_main_q;
    assign {s_axi.bid, s_axi.bresp}                           = b_main_q;
    assign {s_axi.rdata, s_axi.rid, s_axi.rresp, s_axi.rlast} = r_main_q;
endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed self-checking bench for axi_reg_slice: an AW vector table plus
// hand-written sequences for streaming, back-pressure, reverse channels and reset.
module tb_axi_reg_slice;
    localparam int AW = 36;
    localparam int DW = 64;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s_if ();
    axi_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_if ();

    axi_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .s_axi (s_if),
        .m_axi (m_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rdy_vec();
        return {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready};
    endfunction

    function automatic logic [4:0] vld_vec();
        return {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid};
    endfunction

    task automatic idle_all();
        s_if.awaddr = '0; s_if.awid = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
        s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0; s_if.awvalid = 1'b0;
        s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
        s_if.araddr = '0; s_if.arid = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arburst = '0;
        s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0; s_if.arvalid = 1'b0;
        s_if.bready = 1'b0; s_if.rready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
        m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
        m_if.rdata = '0; m_if.rid = '0; m_if.rresp = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
    endtask

    typedef struct {
        logic          vld;
        logic [AW-1:0] addr;
        logic          mrdy;
        logic          exp_rdy;
        logic          exp_vld;
        logic          chk_addr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // AW walk through EMPTY -> ONE -> FULL -> hold -> ONE -> ONE(reload) -> EMPTY
        tbl[0] = '{1'b1, 36'h1000, 1'b0, 1'b1, 1'b1, 1'b1, 36'h1000};
        tbl[1] = '{1'b1, 36'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 36'h1000};
        tbl[2] = '{1'b1, 36'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 36'h1000};
        tbl[3] = '{1'b1, 36'h3000, 1'b1, 1'b1, 1'b1, 1'b1, 36'h2000};
        tbl[4] = '{1'b1, 36'h3000, 1'b1, 1'b1, 1'b1, 1'b1, 36'h3000};
        tbl[5] = '{1'b0, 36'h0,    1'b1, 1'b1, 1'b0, 1'b0, 36'h0};
        tbl[6] = '{1'b1, 36'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 36'h4000};
        tbl[7] = '{1'b0, 36'h0,    1'b0, 1'b1, 1'b1, 1'b1, 36'h4000};
        tbl[8] = '{1'b0, 36'h0,    1'b1, 1'b1, 1'b0, 1'b0, 36'h0};

        // Reset and idle
        idle_all();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_ready", rdy_vec(), 5'b00000);
            chk("reset_valid", vld_vec(), 5'b00000);
        end
        reset = 1'b0;
        step();
        chk("release_ready", rdy_vec(), 5'b11111);
        chk("release_valid", vld_vec(), 5'b00000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ready", rdy_vec(), 5'b11111);
            chk("idle_valid", vld_vec(), 5'b00000);
        end
        $display("reset/idle sequence done");

        // AW vector table
        for (int i = 0; i < 9; i++) begin
            s_if.awvalid = tbl[i].vld;
            s_if.awaddr  = tbl[i].addr;
            m_if.awready = tbl[i].mrdy;
            step();
            chk($sformatf("vec%0d_awready", i), s_if.awready, tbl[i].exp_rdy);
            chk($sformatf("vec%0d_awvalid", i), m_if.awvalid, tbl[i].exp_vld);
            if (tbl[i].chk_addr)
                chk($sformatf("vec%0d_awaddr", i), m_if.awaddr, tbl[i].exp_addr);
            $display("vec %0d: awvalid=%0b awaddr=%h", i, m_if.awvalid, m_if.awaddr);
        end
        s_if.awvalid = 1'b0;
        m_if.awready = 1'b0;

        // Streaming AR: 16 back-to-back beats, output one cycle after acceptance
        m_if.arready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_if.arvalid = 1'b1;
            s_if.araddr  = 36'h8_0000_0000 + AW'(8 * i);
            s_if.arid    = IW'(i);
            step();
            chk("ar_arready", s_if.arready, 1'b1);
            chk("ar_valid", m_if.arvalid, 1'b1);
            chk("ar_addr", m_if.araddr, 36'h8_0000_0000 + AW'(8 * i));
            chk("ar_id", m_if.arid, IW'(i));
            $display("AR beat %0d: araddr=%h arid=%0d", i, m_if.araddr, m_if.arid);
        end
        s_if.arvalid = 1'b0;
        step();
        chk("ar_drain", m_if.arvalid, 1'b0);
        m_if.arready = 1'b0;

        // W back-pressure with an occupancy scoreboard
        begin
            int k = 0, got = 0, c = 0, occ = 0;
            int q[$];
            logic in_f, out_f, stalled;
            logic [DW-1:0] prev_data;
            logic prev_last;
            while (got < 8 && c < 40) begin
                s_if.wvalid  = (k < 8);
                s_if.wdata   = DW'(k);
                s_if.wstrb   = 8'hFF;
                s_if.wlast   = (k == 7);
                m_if.wready  = !(c >= 2 && c < 7);
                in_f    = s_if.wvalid & s_if.wready;
                out_f   = m_if.wvalid & m_if.wready;
                stalled = m_if.wvalid & !m_if.wready;
                prev_data = m_if.wdata;
                prev_last = m_if.wlast;
                if (out_f) begin
                    if (q.size() == 0) begin
                        chk("w_spurious_beat", 1'b1, 1'b0);
                    end else begin
                        int e;
                        e = q.pop_front();
                        chk("w_data", m_if.wdata, DW'(e));
                        chk("w_last", m_if.wlast, (e == 7));
                        chk("w_strb", m_if.wstrb, 8'hFF);
                        $display("W beat %0d: wdata=%0h wlast=%0b", got, m_if.wdata, m_if.wlast);
                    end
                    got++;
                end
                if (in_f) begin
                    q.push_back(k);
                    k++;
                end
                step();
                c++;
                occ = occ + int'(in_f) - int'(out_f);
                chk("w_ready_occ", s_if.wready, (occ < 2));
                chk("w_valid_occ", m_if.wvalid, (occ > 0));
                if (stalled) begin
                    chk("w_stall_data", m_if.wdata, prev_data);
                    chk("w_stall_last", m_if.wlast, prev_last);
                end
            end
            chk("w_beat_count", got, 8);
            s_if.wvalid = 1'b0;
            m_if.wready = 1'b0;
        end

        // Reverse channels: 4 R beats with toggling rready, one B response
        begin
            int k = 0, rgot = 0, bgot = 0, c = 0;
            logic bsent = 1'b0;
            logic r_out, b_in;
            s_if.bready = 1'b1;
            while ((rgot < 4 || bgot < 1) && c < 40) begin
                m_if.rvalid = (k < 4);
                m_if.rdata  = 64'h100 + DW'(k);
                m_if.rid    = IW'(5);
                m_if.rresp  = 2'b00;
                m_if.rlast  = (k == 3);
                m_if.bvalid = !bsent;
                m_if.bid    = IW'(3);
                m_if.bresp  = 2'b00;
                s_if.rready = (c % 2 == 0);
                r_out = s_if.rvalid & s_if.rready;
                b_in  = m_if.bvalid & m_if.bready;
                if (r_out) begin
                    chk("r_data", s_if.rdata, 64'h100 + DW'(rgot));
                    chk("r_id", s_if.rid, IW'(5));
                    chk("r_last", s_if.rlast, (rgot == 3));
                    $display("R beat %0d: rdata=%0h rid=%0d rlast=%0b", rgot, s_if.rdata, s_if.rid, s_if.rlast);
                    rgot++;
                end
                if (s_if.bvalid & s_if.bready) begin
                    chk("b_id", s_if.bid, IW'(3));
                    chk("b_resp", s_if.bresp, 2'b00);
                    $display("B resp: bid=%0d bresp=%0d", s_if.bid, s_if.bresp);
                    bgot++;
                end
                if (m_if.rvalid & m_if.rready) k++;
                if (b_in) bsent = 1'b1;
                step();
                c++;
            end
            chk("r_beat_count", rgot, 4);
            chk("b_count", bgot, 1);
            m_if.rvalid = 1'b0;
            m_if.bvalid = 1'b0;
            s_if.rready = 1'b0;
            s_if.bready = 1'b0;
            step();
            chk("rev_drain", {s_if.bvalid, s_if.rvalid}, 2'b00);
        end

        // AW in ONE with simultaneous in/out fire for 32 cycles
        m_if.awready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [AW+IW+24:0] exp_aw;
            s_if.awvalid = 1'b1;
            s_if.awaddr  = AW'({$urandom(), $urandom()});
            s_if.awid    = IW'($urandom());
            s_if.awlen   = 8'($urandom());
            s_if.awsize  = 3'($urandom());
            s_if.awburst = 2'($urandom());
            s_if.awlock  = 1'($urandom());
            s_if.awcache = 4'($urandom());
            s_if.awprot  = 3'($urandom());
            s_if.awqos   = 4'($urandom());
            exp_aw = {s_if.awaddr, s_if.awid, s_if.awlen, s_if.awsize, s_if.awburst,
                      s_if.awlock, s_if.awcache, s_if.awprot, s_if.awqos};
            step();
            chk("one_awready", s_if.awready, 1'b1);
            chk("one_awvalid", m_if.awvalid, 1'b1);
            chk("one_aw_payload",
                {m_if.awaddr, m_if.awid, m_if.awlen, m_if.awsize, m_if.awburst,
                 m_if.awlock, m_if.awcache, m_if.awprot, m_if.awqos}, exp_aw);
            $display("AW beat %0d: awaddr=%h awid=%0h", i, m_if.awaddr, m_if.awid);
        end
        s_if.awvalid = 1'b0;
        step();
        chk("one_drain", m_if.awvalid, 1'b0);

        // Reset mid-operation: AW FULL, R ONE
        m_if.awready = 1'b0;
        s_if.awvalid = 1'b1;
        s_if.awaddr  = 36'hAAA;
        step();
        s_if.awaddr  = 36'hBBB;
        step();
        s_if.awvalid = 1'b0;
        chk("mid_aw_full", s_if.awready, 1'b0);
        m_if.rvalid = 1'b1;
        m_if.rdata  = 64'hDEAD;
        step();
        m_if.rvalid = 1'b0;
        chk("mid_r_one", s_if.rvalid, 1'b1);
        idle_all();
        reset = 1'b1;
        step();
        chk("mid_reset_valid", vld_vec(), 5'b00000);
        chk("mid_reset_ready", rdy_vec(), 5'b00000);
        step();
        reset = 1'b0;
        step();
        chk("mid_release_ready", rdy_vec(), 5'b11111);
        chk("mid_release_valid", vld_vec(), 5'b00000);
        m_if.awready = 1'b1;
        m_if.arready = 1'b1;
        s_if.awvalid = 1'b1;
        s_if.awaddr  = 36'h123;
        s_if.arvalid = 1'b1;
        s_if.araddr  = 36'h456;
        s_if.arid    = IW'(7);
        step();
        s_if.awvalid = 1'b0;
        s_if.arvalid = 1'b0;
        chk("fresh_awvalid", m_if.awvalid, 1'b1);
        chk("fresh_awaddr", m_if.awaddr, 36'h123);
        chk("fresh_arvalid", m_if.arvalid, 1'b1);
        chk("fresh_araddr", m_if.araddr, 36'h456);
        chk("fresh_arid", m_if.arid, IW'(7));
        $display("fresh AW/AR: awaddr=%h araddr=%h", m_if.awaddr, m_if.araddr);
        step();
        chk("no_stale_valid", vld_vec(), 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_reg_slice.md
Name: axi_reg_slice

Overview:
- Full-throughput AXI4 register slice on all five channels (AW, W, B, AR, R).
- Sits directly downstream of the memory-side address mapper and feeds the DDR/MIG interconnect.
- Breaks every combinational valid/ready/payload path between the mapper and the interconnect, so the remapped address logic and the interconnect close timing independently.
- Does not modify or reorder transactions; every beat is passed unchanged.

Parameters:
- ADDR_WIDTH, 36, width of awaddr/araddr.
- DATA_WIDTH, 64, width of wdata/rdata; wstrb is DATA_WIDTH/8.
- ID_WIDTH, 16, width of awid/arid/bid/rid.

Ports:
- clk  input  1  single clock for all channels.
- reset  input  1  synchronous, active-high reset.
- s_axi_*  slave  AXI4 bundle (ADDR_WIDTH, DATA_WIDTH, ID_WIDTH)  upstream side, from the address mapper.
  - AW channel: awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid/awready.
  - W channel: wdata, wstrb, wlast, wvalid/wready.
  - B channel: bid, bresp, bvalid/bready.
  - AR channel: the AR fields mirroring AW, plus arvalid/arready.
  - R channel: rdata, rid, rresp, rlast, rvalid/rready.
- m_axi_*  master  identical AXI4 bundle  downstream side, to the interconnect.
- No user signals.
- Interface: one clock; reset is synchronous and active-high.

Behaviour:
- One independent skid-buffer instance per channel.
  - Forward channels (AW, W, AR): input is s_axi, output is m_axi.
  - Reverse channels (B, R): input is m_axi, output is s_axi.
- Per-channel storage: main register plus skid register, each holding the full payload.
- Per-channel state machine:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1; main register holds data.
  - FULL: out_valid=1, in_ready=0; main and skid registers both hold data.
- Transitions (in_fire = in_valid & in_ready; out_fire = out_valid & out_ready):
  - EMPTY, in_fire -> ONE; payload loads into main.
  - ONE, in_fire & !out_fire -> FULL; payload loads into skid.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, in_fire & out_fire -> ONE; main reloads with the new payload.
  - FULL, out_fire -> ONE; skid moves into main. in_ready is 0, so no input is accepted in this state.
  - All other cases: hold.
- in_ready and out_valid come directly from flops; no combinational path from any input to any output.
- Output payload = main register. Payload is don't-care while out_valid=0, but must not change while out_valid=1 and out_ready=0.
- Latency: a beat accepted in cycle N is presented at the output in cycle N+1.
- Throughput: one beat per cycle sustained on each channel with out_ready held high.
- Back-pressure: at most 2 beats absorbed per channel after out_ready drops. in_ready deasserts the cycle after the second beat is accepted.
- Ordering: strict FIFO per channel; beats are never dropped or duplicated.
- AW and W are not synchronised to each other; W may lead AW, as AXI permits.
- Reset:
  - While reset=1: all out_valid=0, all in_ready=0, state=EMPTY, payload registers unchanged.
  - First cycle after reset deasserts: in_ready=1.
  - Reset asserted mid-burst discards buffered beats on every channel; system-level reset of both neighbours is required.
- Valid held without ready: the slice keeps out_valid and payload stable until out_fire, per AXI.
- Never deasserts out_valid without out_fire.

Test Plan:
1. Reset then idle: reset=1 for 3 cycles. Required: all *valid=0 and all *ready=0 during reset; all in-side ready=1 on the cycle after release; no outputs toggle with no stimulus.
2. Streaming AR: 16 back-to-back reads, araddr=0x8_0000_0000+8*i, arid=i, m_axi_arready=1. Required: m_axi_araddr/arid appear one cycle after acceptance, in order, 16 consecutive valid cycles, no bubbles.
3. Back-pressure W: 8-beat write burst (wdata=i, wstrb=0xFF, wlast on beat 7), m_axi_wready=0 from beat 2 for 5 cycles. Required: s_axi_wready drops after exactly 2 unaccepted beats are buffered; all 8 beats emerge in order with wlast only on beat 7; m_axi_w payload stable while stalled.
4. Reverse channels: interconnect returns rid=5 with 4 beats (rlast on 4th) and bid=3 bresp=OKAY, while s_axi_rready toggles 1,0,1,0. Required: s_axi_r beats arrive in order with rid=5 and correct rlast; s_axi_bid=3, bresp=0; no beat lost.
5. Simultaneous in/out in ONE state: hold out_ready=1 and present a new beat every cycle for 32 cycles with random AW fields. Required: state never reaches FULL; output sequence equals input sequence delayed by one cycle.
6. Reset mid-operation: assert reset with AW in FULL and R in ONE. Required: next cycle all valids=0; after release, fresh AW/AR transactions complete normally with no stale beats.
